// File: rtl/obj_line_renderer.sv
// obj_line_renderer
//
// Consumer end of the 32-bit object-state bus driven by the tank/bullet engines.
// For every scanline it scans the NUM_OBJ state words from NUM_OBJ-1 down to 0.
// It fetches the visible row of each object's sprite from the sprite ROM and paints
// that row into the build half of a ping-pong line buffer. The VGA side reads the
// other half one pixel at a time. A read also clears the pixel it returns, so a half
// is already blank when it comes back as the build buffer.
//
// Ports
//   clk, reset   clock; synchronous active-high reset
//   obj_state    NUM_OBJ packed words, word i at [32*i +: 32]:
//                {pad, type[1:0], active, x[9:0], y[9:0], dir[1:0], rom_row[2:0], rom_col[2:0]}
//   line_start   1-cycle pulse: swap buffers and start building line line_y
//   line_y       line to build, sampled with line_start
//   rom_addr     {rom_row, rom_col, sprite_row[4:0], sprite_col[4:0]}
//   rom_data     sprite pixel, valid one cycle after rom_addr; 0 = transparent
//   pix_rd/pix_x VGA-side read strobe and column
//   pix_color    colour of pix_x, one cycle after pix_rd; holds when there is no read
//   pix_opaque   pix_color != 0
//   build_busy   build FSM not idle (also high during the post-reset clear)
//   overrun      sticky: a line_start arrived while a build was still running
//
// Optional feature macro: RENDER_STATS_EN adds the following outputs:
//   obj_hits     number of objects hit on the last completed build
//   overrun_cnt  saturating count of overrun events

module obj_line_renderer #(
  parameter int NUM_OBJ     = 16,
  parameter int LINE_W      = 640,
  parameter int COLOR_W     = 4,
  parameter int TANK_SIZE   = 32,
  parameter int BULLET_SIZE = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [32*NUM_OBJ-1:0]  obj_state,
  input  logic                   line_start,
  input  logic [9:0]             line_y,
  output logic [15:0]            rom_addr,
  input  logic [COLOR_W-1:0]     rom_data,
  input  logic                   pix_rd,
  input  logic [9:0]             pix_x,
  output logic [COLOR_W-1:0]     pix_color,
  output logic                   pix_opaque,
  output logic                   build_busy,
  output logic                   overrun
`ifdef RENDER_STATS_EN
  , output logic [$clog2(NUM_OBJ+1)-1:0] obj_hits
  , output logic [7:0]                   overrun_cnt
`endif
);

  localparam int IDX_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
  localparam int XA_W  = $clog2(LINE_W);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_CHECK, S_FETCH} state_t;

  state_t state, state_nxt;

  logic [COLOR_W-1:0] buf0 [LINE_W];
  logic [COLOR_W-1:0] buf1 [LINE_W];

  logic             disp_sel;
  logic [XA_W-1:0]  clr_cnt;
  logic [9:0]       line_q;
  logic [IDX_W-1:0] idx;
  logic [4:0]       col;
  logic             pend_valid;
  logic [10:0]      pend_addr;

  logic [31:0] obj_words [NUM_OBJ];
  logic [31:0] cur_obj;
  logic [1:0]  cur_type;
  logic        cur_active;
  logic [9:0]  cur_x, cur_y;
  logic [2:0]  cur_rrow, cur_rcol;
  logic [5:0]  cur_size;
  logic [10:0] y_end;
  logic [4:0]  sprite_row;
  logic        hit, last_col, last_obj;
  logic        start, abort;
  logic        bld_we, rd_clr;
  logic [COLOR_W-1:0] rd_val;
  logic        unused_bits;

  for (genvar g = 0; g < NUM_OBJ; g++) begin : g_words
    assign obj_words[g] = obj_state[32*g +: 32];
  end

  assign cur_obj    = obj_words[idx];
  assign cur_type   = cur_obj[30:29];
  assign cur_active = cur_obj[28];
  assign cur_x      = cur_obj[27:18];
  assign cur_y      = cur_obj[17:8];
  assign cur_rrow   = cur_obj[5:3];
  assign cur_rcol   = cur_obj[2:0];
  // pad and dir do not affect rendering
  assign unused_bits = ^{cur_obj[31], cur_obj[7:6]};

  assign cur_size   = (cur_type == 2'b01) ? 6'(BULLET_SIZE) : 6'(TANK_SIZE);
  // 11-bit bottom edge so a sprite near y=1023 cannot wrap around to the top
  assign y_end      = {1'b0, cur_y} + {5'b0, cur_size};
  assign hit        = cur_active && (line_q >= cur_y) && ({1'b0, line_q} < y_end);
  assign sprite_row = line_q[4:0] - cur_y[4:0];
  assign last_col   = ({1'b0, col} == (cur_size - 6'd1));
  assign last_obj   = (idx == '0);

  assign start  = line_start && (state != S_CLEAR);
  assign abort  = line_start && ((state == S_CHECK) || (state == S_FETCH));

  assign build_busy = (state != S_IDLE);

  // The pending write lands one cycle after its fetch. It still lands in the first
  // IDLE cycle. An abort drops it.
  assign bld_we = pend_valid && (rom_data != '0) && (pend_addr < 11'(LINE_W)) && !abort;
  assign rd_clr = pix_rd && ({1'b0, pix_x} < 11'(LINE_W)) && (state != S_CLEAR);
  assign rd_val = disp_sel ? buf1[pix_x[XA_W-1:0]] : buf0[pix_x[XA_W-1:0]];

  always_comb begin
    rom_addr = 16'h0;
    if (state == S_FETCH) rom_addr = {cur_rrow, cur_rcol, sprite_row, col};
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_CLEAR;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR: if (clr_cnt == XA_W'(LINE_W-1)) state_nxt = S_IDLE;
      S_IDLE:  if (line_start) state_nxt = S_CHECK;
      S_CHECK: begin
        if (line_start)    state_nxt = S_CHECK;
        else if (hit)      state_nxt = S_FETCH;
        else if (last_obj) state_nxt = S_IDLE;
        else               state_nxt = S_CHECK;
      end
      S_FETCH: begin
        if (line_start)    state_nxt = S_CHECK;
        else if (last_col) state_nxt = last_obj ? S_IDLE : S_CHECK;
        else               state_nxt = S_FETCH;
      end
      default: state_nxt = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      disp_sel   <= 1'b0;
      clr_cnt    <= '0;
      line_q     <= '0;
      idx        <= '0;
      col        <= '0;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      overrun    <= 1'b0;
    end else begin
      if (state == S_CLEAR) clr_cnt <= clr_cnt + 1'b1;
      pend_valid <= (state == S_FETCH) && !line_start;
      pend_addr  <= {1'b0, cur_x} + {6'b0, col};
      if (abort) overrun <= 1'b1;
      if (start) begin
        disp_sel <= ~disp_sel;
        line_q   <= line_y;
        idx      <= IDX_W'(NUM_OBJ-1);
      end else begin
        if (state == S_CHECK) begin
          col <= '0;
          if (!hit && !last_obj) idx <= idx - 1'b1;
        end
        if (state == S_FETCH) begin
          col <= col + 1'b1;
          if (last_col && !last_obj) idx <= idx - 1'b1;
        end
      end
    end
  end

  // Each half has one write port. The post-reset clear uses it first. After that,
  // clear-on-read uses it while the half is displayed, and sprite writes use it
  // while the half is being built.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR)       buf0[clr_cnt] <= '0;
    else if (!disp_sel) begin
      if (rd_clr)               buf0[pix_x[XA_W-1:0]] <= '0;
    end else if (bld_we)        buf0[pend_addr[XA_W-1:0]] <= rom_data;
  end

  always_ff @(posedge clk) begin
    if (state == S_CLEAR)       buf1[clr_cnt] <= '0;
    else if (disp_sel) begin
      if (rd_clr)               buf1[pix_x[XA_W-1:0]] <= '0;
    end else if (bld_we)        buf1[pend_addr[XA_W-1:0]] <= rom_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_color  <= '0;
      pix_opaque <= 1'b0;
    end else if (pix_rd) begin
      if (rd_clr) begin
        pix_color  <= rd_val;
        pix_opaque <= (rd_val != '0);
      end else begin
        pix_color  <= '0;
        pix_opaque <= 1'b0;
      end
    end
  end

`ifdef RENDER_STATS_EN
  logic [$clog2(NUM_OBJ+1)-1:0] hit_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt     <= '0;
      obj_hits    <= '0;
      overrun_cnt <= '0;
    end else begin
      if (start)                             hit_cnt <= '0;
      else if ((state == S_CHECK) && hit)    hit_cnt <= hit_cnt + 1'b1;
      // a build that finishes without being aborted publishes its hit count
      if (!line_start && ((state == S_CHECK) || (state == S_FETCH)) && (state_nxt == S_IDLE))
        obj_hits <= hit_cnt + (((state == S_CHECK) && hit) ? 1'b1 : 1'b0);
      if (abort && (overrun_cnt != 8'hFF))   overrun_cnt <= overrun_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_obj_line_renderer.sv
// tb_obj_line_renderer
//
// Directed and randomized bench for obj_line_renderer. It includes a behavioural
// sprite ROM. It also keeps a reference model of both line-buffer halves: each build
// paints whole sprite rows in descending object order, and each read returns the
// pixel and then clears it.

module tb_obj_line_renderer;

  localparam int NUM_OBJ = 16;
  localparam int LINE_W  = 640;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [32*NUM_OBJ-1:0] obj_state;
  logic                  line_start;
  logic [9:0]            line_y;
  logic [15:0]           rom_addr;
  logic [3:0]            rom_data;
  logic                  pix_rd;
  logic [9:0]            pix_x;
  logic [3:0]            pix_color;
  logic                  pix_opaque;
  logic                  build_busy;
  logic                  overrun;
`ifdef RENDER_STATS_EN
  logic [4:0]            obj_hits;
  logic [7:0]            overrun_cnt;
`endif

  obj_line_renderer dut (
    .clk(clk), .reset(reset), .obj_state(obj_state),
    .line_start(line_start), .line_y(line_y),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .pix_rd(pix_rd), .pix_x(pix_x),
    .pix_color(pix_color), .pix_opaque(pix_opaque),
    .build_busy(build_busy), .overrun(overrun)
`ifdef RENDER_STATS_EN
    , .obj_hits(obj_hits), .overrun_cnt(overrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] objs [NUM_OBJ];
  always_comb begin
    obj_state = '0;
    for (int i = 0; i < NUM_OBJ; i++) obj_state[32*i +: 32] = objs[i];
  end

  int total = 0;
  int bad   = 0;

  // The ROM contents are selected by rom_mode:
  //   0 = constant rom_val
  //   1 = address hash, which includes transparent zeros
  //   2 = rom_row 0 transparent for cols 0..3
  //   3 = colour from rom_row only
  int rom_mode = 0;
  int rom_val  = 5;
  int salt     = 0;

  function automatic logic [3:0] rom_fn(input logic [15:0] a);
    int row, rc, sr, sc;
    row = int'(a[15:13]); rc = int'(a[12:10]); sr = int'(a[9:5]); sc = int'(a[4:0]);
    case (rom_mode)
      0:       return 4'(rom_val);
      1:       return 4'((row*3 + rc*5 + sr*11 + sc*7 + salt) % 16);
      2:       return (row == 0 && sc < 4) ? 4'd0 : 4'(row*2 + 1);
      default: return 4'(row*2 + 1);
    endcase
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  int rom_nz = 0;
  always @(posedge clk) if (rom_addr != 16'h0) rom_nz <= rom_nz + 1;

  // reference model state
  int mbuf   [2][LINE_W];
  int prev_b [LINE_W];
  int m_disp = 0;
  int m_build = 1;
  int m_hits = 0;

  function automatic logic [31:0] mk_obj(input int typ, input int act, input int x,
                                         input int y, input int rr, input int rc);
    return {1'($urandom % 2), 2'(typ), 1'(act), 10'(x), 10'(y), 2'($urandom % 4), 3'(rr), 3'(rc)};
  endfunction

  task automatic clear_objs();
    for (int i = 0; i < NUM_OBJ; i++) objs[i] = mk_obj(0, 0, 0, 0, 1, 1);
  endtask

  task automatic model_paint(input int b, input int ly);
    int hits = 0;
    for (int i = NUM_OBJ-1; i >= 0; i--) begin
      logic [31:0] w;
      int s, ox, oy;
      w  = objs[i];
      s  = (w[30:29] == 2'b01) ? 8 : 32;
      ox = int'(w[27:18]);
      oy = int'(w[17:8]);
      if (w[28] && ly >= oy && ly < oy + s) begin
        hits++;
        for (int c = 0; c < s; c++) begin
          int v;
          if (ox + c < LINE_W) begin
            v = int'(rom_fn({w[5:3], w[2:0], 5'(ly - oy), 5'(c)}));
            if (v != 0) mbuf[b][ox + c] = v;
          end
        end
      end
    end
    m_hits = hits;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // pulses line_start for one cycle and advances the model the same way
  task automatic applyStimulus(input int ly);
    line_start = 1'b1;
    line_y     = 10'(ly);
    @(negedge clk);
    line_start = 1'b0;
    m_disp  = 1 - m_disp;
    m_build = 1 - m_disp;
    for (int x = 0; x < LINE_W; x++) prev_b[x] = mbuf[m_build][x];
    model_paint(m_build, ly);
  endtask

  task automatic wait_build(output int n);
    n = 1;
    while (build_busy === 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("build_done", 32'(build_busy), 32'd0);
    @(negedge clk);
  endtask

  task automatic read_px(input int x, output logic [3:0] c, output logic o);
    pix_rd = 1'b1;
    pix_x  = 10'(x);
    @(negedge clk);
    c = pix_color;
    o = pix_opaque;
    pix_rd = 1'b0;
  endtask

  task automatic read_line_check(input string tag);
    logic [3:0] c;
    logic o;
    for (int x = 0; x < LINE_W; x++) begin
      read_px(x, c, o);
      checkOutput($sformatf("%s_col[%0d]", tag, x), 32'(c), 32'(mbuf[m_disp][x]));
      checkOutput($sformatf("%s_opq[%0d]", tag, x), 32'(o), 32'(mbuf[m_disp][x] != 0));
      mbuf[m_disp][x] = 0;
    end
  endtask

  initial begin
    int n, ly, ly2, nz0;
    logic [3:0] c;
    logic o;
    int full_a [LINE_W];
    int prev_a [LINE_W];
    int part_b;

    reset = 1'b1; line_start = 1'b0; line_y = '0; pix_rd = 1'b0; pix_x = '0;
    clear_objs();
    for (int b = 0; b < 2; b++) for (int x = 0; x < LINE_W; x++) mbuf[b][x] = 0;

    // 1: reset values, clear length, blank buffer
    repeat (3) @(negedge clk);
    checkOutput("rst_pix_color", 32'(pix_color), 32'd0);
    checkOutput("rst_pix_opaque", 32'(pix_opaque), 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);
    checkOutput("rst_rom_addr", 32'(rom_addr), 32'd0);
    checkOutput("rst_build_busy", 32'(build_busy), 32'd1);
`ifdef RENDER_STATS_EN
    checkOutput("rst_obj_hits", 32'(obj_hits), 32'd0);
    checkOutput("rst_overrun_cnt", 32'(overrun_cnt), 32'd0);
`endif
    reset = 1'b0;
    n = 0;
    while (build_busy === 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("clear_cycles", 32'(n), 32'(LINE_W));
    read_line_check("t1");
    $display("[TB] reset/clear section complete");

    // 2: single bullet, colour 5, clear-on-read, hold, out-of-range read
    rom_mode = 0; rom_val = 5;
    objs[0] = mk_obj(1, 1, 100, 50, 0, 1);
    applyStimulus(53); wait_build(n);
    applyStimulus(54); wait_build(n);
`ifdef RENDER_STATS_EN
    checkOutput("t2_obj_hits", 32'(obj_hits), 32'd1);
`endif
    for (int x = 99; x <= 108; x++) begin
      if (x == 100) continue;
      read_px(x, c, o);
      checkOutput($sformatf("t2_col[%0d]", x), 32'(c), (x >= 100 && x <= 107) ? 32'd5 : 32'd0);
      checkOutput($sformatf("t2_opq[%0d]", x), 32'(o), (x >= 100 && x <= 107) ? 32'd1 : 32'd0);
      mbuf[m_disp][x] = 0;
    end
    read_px(100, c, o);
    checkOutput("t2_col[100]", 32'(c), 32'd5);
    pix_x = 10'd3;
    repeat (3) @(negedge clk);
    checkOutput("t2_hold_col", 32'(pix_color), 32'd5);
    checkOutput("t2_hold_opq", 32'(pix_opaque), 32'd1);
    read_px(100, c, o);
    checkOutput("t2_reread", 32'(c), 32'd0);
    mbuf[m_disp][100] = 0;
    read_px(700, c, o);
    checkOutput("t2_oob", 32'(c), 32'd0);
    read_line_check("t2");

    // 3: tank under bullet, bullet on top
    rom_mode = 3;
    clear_objs();
    objs[3] = mk_obj(0, 1, 96, 40, 2, 0);
    objs[0] = mk_obj(1, 1, 100, 40, 0, 0);
    applyStimulus(44); wait_build(n);
    applyStimulus(44); wait_build(n);
    read_line_check("t3");

    // 4: inactive objects fetch nothing; tank at the right edge
    rom_mode = 0; rom_val = 9;
    for (int i = 0; i < NUM_OBJ; i++) objs[i] = mk_obj(2, 0, 20*i, 300, 3, 2);
    nz0 = rom_nz;
    applyStimulus(300); wait_build(n);
    checkOutput("t4_miss_cycles", 32'(n), 32'(NUM_OBJ + 1));
    checkOutput("t4_no_rom", 32'(rom_nz - nz0), 32'd0);
    objs[5] = mk_obj(2, 1, 620, 300, 3, 2);
    applyStimulus(305); wait_build(n);
    applyStimulus(305); wait_build(n);
    read_px(700, c, o);
    checkOutput("t4_oob", 32'(c), 32'd0);
    read_line_check("t4");

    // 6: transparent bullet columns show the tank underneath
    rom_mode = 2;
    clear_objs();
    objs[2] = mk_obj(0, 1, 50, 80, 3, 1);
    objs[0] = mk_obj(1, 1, 60, 82, 0, 4);
    applyStimulus(85); wait_build(n);
    applyStimulus(85); wait_build(n);
    read_line_check("t6");

    // 5: overrun on a 16-tank line, partial line, recovery
    checkOutput("t5_overrun_pre", 32'(overrun), 32'd0);
    rom_mode = 1; salt = 3;
    for (int i = 0; i < NUM_OBJ; i++) objs[i] = mk_obj(0, 1, 40*i, 200, i % 8, (i * 3) % 8);
    applyStimulus(210);
    part_b = m_build;
    for (int x = 0; x < LINE_W; x++) begin
      full_a[x] = mbuf[part_b][x];
      prev_a[x] = prev_b[x];
    end
    repeat (99) @(negedge clk);
    checkOutput("t5_busy_mid", 32'(build_busy), 32'd1);
    applyStimulus(210);
    checkOutput("t5_overrun", 32'(overrun), 32'd1);
    wait_build(n);
    for (int x = 0; x < LINE_W; x++) begin
      read_px(x, c, o);
      if (x >= 600 && x < 632)
        checkOutput($sformatf("t5_obj15[%0d]", x), 32'(c), 32'(full_a[x]));
      else
        checkOutput($sformatf("t5_part[%0d]", x),
                    32'((32'(c) == full_a[x]) || (32'(c) == prev_a[x])), 32'd1);
      mbuf[part_b][x] = 0;
    end
    applyStimulus(210); wait_build(n);
    checkOutput("t5_overrun_sticky", 32'(overrun), 32'd1);
`ifdef RENDER_STATS_EN
    checkOutput("t5_obj_hits", 32'(obj_hits), 32'(NUM_OBJ));
    checkOutput("t5_overrun_cnt", 32'(overrun_cnt), 32'd1);
`endif
    read_line_check("t5");

    // random objects and lines against the model
    for (int r = 0; r < 5; r++) begin
      rom_mode = 1;
      salt = int'($urandom % 16);
      ly = int'($urandom_range(40, 470));
      for (int i = 0; i < NUM_OBJ; i++)
        objs[i] = mk_obj(int'($urandom % 4), int'(($urandom % 4) != 0),
                         int'($urandom_range(0, 639)), ly - int'($urandom_range(0, 40)),
                         int'($urandom % 8), int'($urandom % 8));
      ly2 = ly + int'($urandom_range(0, 3));
      applyStimulus(ly); wait_build(n);
`ifdef RENDER_STATS_EN
      checkOutput($sformatf("rnd%0d_hits", r), 32'(obj_hits), 32'(m_hits));
`endif
      applyStimulus(ly2); wait_build(n);
      read_line_check($sformatf("rnd%0d", r));
    end

    // reset clears the sticky flag
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst2_overrun", 32'(overrun), 32'd0);
    checkOutput("rst2_busy", 32'(build_busy), 32'd1);
    checkOutput("rst2_pix_color", 32'(pix_color), 32'd0);
    checkOutput("rst2_rom_addr", 32'(rom_addr), 32'd0);
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
